// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Optional sign-magnitude support is enabled with SEQ_DIVIDER_SIGN_MAG_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_M_DEFAULT = 64;
    localparam int DIV_LATENCY   = DIV_M_DEFAULT;

    // The iteration counter must hold m-1.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when it did not go negative.
module div_step #(
    parameter int m = 64
) (
    input  logic [m-1:0] p_in,
    input  logic         n_bit,
    input  logic [m-1:0] d,
    output logic [m:0]   p_out,
    output logic         q_bit
);

    logic [m:0]   shifted;
    logic [m+1:0] diff;

    // One spare bit above the m+1-bit step difference carries the borrow.
    always_comb begin
        shifted = {p_in, n_bit};
        diff    = {1'b0, shifted} - {2'b00, d};
        q_bit   = ~diff[m+1];
        p_out   = q_bit ? diff[m:0] : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with valid/ready handshakes on both sides.
// Define SEQ_DIVIDER_SIGN_MAG_EN to add sign-magnitude operand handling.
module seq_divider
    import div_pkg::*;
#(
    parameter int m = DIV_M_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [m-1:0] dividend,
    input  logic [m-1:0] divisor,
    input  logic         sgn_n,
    input  logic         sgn_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [m-1:0] quotient,
    output logic [m-1:0] remainder,
    output logic         sgn_q,
    output logic         sgn_r,
    output logic         div_by_zero,
    output logic [1:0]   dbg_state
);

    localparam int CW = cnt_width(m);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE,
    // and DONE holds its outputs until out_ready is seen.
    state_t          state_q, state_d;
    logic [m-1:0]    n_q, n_d;
    logic [m-1:0]    d_q, d_d;
    logic [m:0]      p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dbz_q, dbz_d;
    logic [m:0]      step_p;
    logic            step_q;
    logic            unused_p_msb;

    div_step #(.m(m)) u_step (
        .p_in  (p_q[m-1:0]),
        .n_bit (n_q[m-1]),
        .d     (d_q),
        .p_out (step_p),
        .q_bit (step_q)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d = divisor;
                    if (divisor == '0) begin
                        n_d     = '1;
                        p_d     = {1'b0, dividend};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        n_d     = dividend;
                        p_d     = '0;
                        cnt_d   = CW'(m - 1);
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Quotient bits enter at the LSB as dividend bits leave the MSB.
                n_d   = {n_q[m-2:0], step_q};
                p_d   = step_p;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign quotient     = out_valid ? n_q : '0;
    assign remainder    = out_valid ? p_q[m-1:0] : '0;
    assign div_by_zero  = out_valid & dbz_q;
    assign dbg_state    = state_q;
    // The partial remainder stays below the divisor, so its top bit is always 0.
    assign unused_p_msb = p_q[m];

`ifdef SEQ_DIVIDER_SIGN_MAG_EN
    logic sgn_n_q, sgn_n_d;
    logic sgn_d_q, sgn_d_d;

    always_comb begin
        sgn_n_d = sgn_n_q;
        sgn_d_d = sgn_d_q;
        if (state_q == IDLE && in_valid) begin
            sgn_n_d = sgn_n;
            sgn_d_d = sgn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_n_q <= 1'b0;
            sgn_d_q <= 1'b0;
        end else begin
            sgn_n_q <= sgn_n_d;
            sgn_d_q <= sgn_d_d;
        end
    end

    // A zero magnitude never carries a negative sign.
    assign sgn_q = out_valid & (quotient != '0) & (dbz_q ? sgn_n_q : (sgn_n_q ^ sgn_d_q));
    assign sgn_r = out_valid & (remainder != '0) & sgn_n_q;
`else
    logic unused_sgn;
    assign unused_sgn = sgn_n ^ sgn_d;
    assign sgn_q      = 1'b0;
    assign sgn_r      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at m=8 against an arithmetic reference.
// Sign-magnitude checks are active when SEQ_DIVIDER_SIGN_MAG_EN is defined.
module tb_seq_divider;
  import div_pkg::*;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic         sgn_n = 1'b0;
  logic         sgn_d = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [M-1:0] quotient;
  logic [M-1:0] remainder;
  logic         sgn_q;
  logic         sgn_r;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic [2*M-1:0] exp_q[$];

  seq_divider #(.m(M)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .sgn_n       (sgn_n),
    .sgn_d       (sgn_d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .sgn_q       (sgn_q),
    .sgn_r       (sgn_r),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [M-1:0] n, input logic [M-1:0] d,
                          input logic sn, input logic sd, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: got %b want 1", in_ready);
    end
    dividend = n;
    divisor  = d;
    sgn_n    = sn;
    sgn_d    = sd;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout: got %b want 1 after %0d cycles", out_valid, lat);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // reference model
  function automatic logic [2*M-1:0] ref_div(input logic [M-1:0] n, input logic [M-1:0] d);
    int unsigned nq, nr;
    if (d == 0) begin
      nq = (1 << M) - 1;
      nr = n;
    end else begin
      nq = n / d;
      nr = n % d;
    end
    return {nq[M-1:0], nr[M-1:0]};
  endfunction

  function automatic logic [1:0] ref_sign(input logic [M-1:0] n, input logic [M-1:0] d,
                                          input logic sn, input logic sd);
    logic [2*M-1:0] qr;
    logic sq, sr;
    qr = ref_div(n, d);
`ifdef SEQ_DIVIDER_SIGN_MAG_EN
    sq = (qr[2*M-1:M] != 0) && ((d == 0) ? sn : (sn ^ sd));
    sr = (qr[M-1:0] != 0) && sn;
`else
    sq = 1'b0;
    sr = 1'b0;
`endif
    return {sq, sr};
  endfunction

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (dbg_state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d in_ready=%b out_valid=%b want 0/1/0",
               dbg_state, in_ready, out_valid);
    end
    vectors++;
    if (quotient !== 0 || remainder !== 0 || div_by_zero !== 0 || sgn_q !== 0 || sgn_r !== 0) begin
      errors++;
      $display("FAIL reset_data: q=%0d r=%0d dbz=%b sq=%b sr=%b want all 0",
               quotient, remainder, div_by_zero, sgn_q, sgn_r);
    end
  endtask

  task automatic test_basic_hold();
    int lat;
    logic [M-1:0] q0, r0;
    start_op(8'd200, 8'd7, 1'b0, 1'b0, lat);
    vectors++;
    if (lat !== M) begin
      errors++;
      $display("FAIL basic_latency: got %0d want %0d", lat, M);
    end
    vectors++;
    if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_200_7: q=%0d r=%0d dbz=%b want 28/4/0", quotient, remainder, div_by_zero);
    end
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4) begin
        errors++;
        $display("FAIL hold_%0d: v=%b q=%0d r=%0d want 1/%0d/%0d", i, out_valid, quotient, remainder, q0, r0);
      end
    end
    finish_op();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(8'd255, 8'd1, 1'b0, 1'b0, lat);
    vectors++;
    if (quotient !== 8'd255 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL b2b_255_1: q=%0d r=%0d want 255/0", quotient, remainder);
    end
    finish_op();
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    start_op(8'd5, 8'd9, 1'b0, 1'b0, lat);
    vectors++;
    if (quotient !== 8'd0 || remainder !== 8'd5 || lat !== M) begin
      errors++;
      $display("FAIL b2b_5_9: q=%0d r=%0d lat=%0d want 0/5/%0d", quotient, remainder, lat, M);
    end
    finish_op();
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(8'd100, 8'd0, 1'b0, 1'b0, lat);
    vectors++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL dbz_latency: extra cycles=%0d want 0", lat);
    end
    vectors++;
    if (quotient !== 8'hFF || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_100: q=%0h r=%0d dbz=%b want ff/100/1", quotient, remainder, div_by_zero);
    end
    finish_op();
    vectors++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: got %b want 0", div_by_zero);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (dbg_state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        quotient !== 0 || remainder !== 0 || div_by_zero !== 0) begin
      errors++;
      $display("FAIL mid_run_reset: st=%0d rdy=%b v=%b q=%0d r=%0d dbz=%b want idle/1/0/0/0/0",
               dbg_state, in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    start_op(8'd9, 8'd3, 1'b0, 1'b0, lat);
    vectors++;
    if (quotient !== 8'd3 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_9_3: q=%0d r=%0d want 3/0", quotient, remainder);
    end
    finish_op();
  endtask

  task automatic test_in_valid_ignored();
    int lat;
    dividend = 8'd200;
    divisor  = 8'd7;
    in_valid = 1'b1;
    step();
    lat = 0;
    while (!out_valid && lat < 50) begin
      in_valid = $urandom_range(0, 1);
      dividend = $urandom_range(0, 255);
      divisor  = $urandom_range(0, 255);
      step();
      lat++;
    end
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4 || lat !== M) begin
      errors++;
      $display("FAIL ignore_in_valid: v=%b q=%0d r=%0d lat=%0d want 1/28/4/%0d",
               out_valid, quotient, remainder, lat, M);
    end
    finish_op();
  endtask

  task automatic test_sign_mag();
    int lat;
    logic [1:0] es;
    start_op(8'd100, 8'd7, 1'b1, 1'b0, lat);
    es = ref_sign(8'd100, 8'd7, 1'b1, 1'b0);
    vectors++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || {sgn_q, sgn_r} !== es) begin
      errors++;
      $display("FAIL sign_m100_7: q=%0d r=%0d s=%b%b want 14/2/%b", quotient, remainder, sgn_q, sgn_r, es);
    end
    finish_op();
    start_op(8'd0, 8'd3, 1'b0, 1'b1, lat);
    vectors++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || sgn_q !== 1'b0 || sgn_r !== 1'b0) begin
      errors++;
      $display("FAIL sign_0_m3: q=%0d r=%0d s=%b%b want 0/0/00", quotient, remainder, sgn_q, sgn_r);
    end
    finish_op();
    start_op(8'd37, 8'd0, 1'b1, 1'b0, lat);
    es = ref_sign(8'd37, 8'd0, 1'b1, 1'b0);
    vectors++;
    if (div_by_zero !== 1'b1 || {sgn_q, sgn_r} !== es) begin
      errors++;
      $display("FAIL sign_dbz: dbz=%b s=%b%b want 1/%b", div_by_zero, sgn_q, sgn_r, es);
    end
    finish_op();
  endtask

  task automatic test_random(input int count);
    int lat;
    logic [M-1:0] n, d;
    logic sn, sd;
    logic [2*M-1:0] exp;
    logic [1:0] es;
    int unsigned prod;
    for (int i = 0; i < count; i++) begin
      n  = $urandom_range(0, 255);
      d  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      sn = $urandom_range(0, 1);
      sd = $urandom_range(0, 1);
      exp_q.push_back(ref_div(n, d));
      es = ref_sign(n, d, sn, sd);
      start_op(n, d, sn, sd, lat);
      exp = exp_q.pop_front();
      vectors++;
      if ({quotient, remainder} !== exp || div_by_zero !== (d == 0) || {sgn_q, sgn_r} !== es) begin
        errors++;
        $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d dbz=%b s=%b%b want q=%0d r=%0d s=%b",
                 i, n, d, quotient, remainder, div_by_zero, sgn_q, sgn_r, exp[2*M-1:M], exp[M-1:0], es);
      end
      if (d != 0) begin
        prod = quotient * d + remainder;
        vectors++;
        if (prod !== n || remainder >= d) begin
          errors++;
          $display("FAIL rand_invariant_%0d: q*d+r=%0d want %0d, r=%0d d=%0d", i, prod, n, remainder, d);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++) step();
      end
      finish_op();
    end
  endtask

  // run + final report
  initial begin
    test_reset();
    test_basic_hold();
    test_back_to_back();
    test_div_zero();
    test_reset_mid_run();
    test_in_valid_ignored();
    test_sign_mag();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
